synapse_port_scheduler: RTL and testbench
=========================================

# synapse_port_scheduler

Arbitrates the single synapse-memory port of a processing neuron among three requesters: AXI parameter writes, STDP synaptic-weight updates, and spike-driven weight reads. It sits between the address-decode front end and the 128-entry synapse memory. It expands a two-neuron spike address into two back-to-back reads and returns tagged read data to the soma side.

## Interface
Parameters:
- AW, 7, synapse memory address width (128 entries)
- DW, 32, synapse memory data width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_valid / cfg_ready  in / out  1  AXI parameter-write handshake
- cfg_addr  in  AW  synapse write address
- cfg_data  in  DW  synapse write data
- swu_valid / swu_ready  in / out  1  STDP weight-update handshake
- swu_addr  in  AW  updated synapse address
- swu_data  in  8  new weight, zero-extended to DW
- spk_valid / spk_ready  in / out  1  spike-read handshake
- spk_addr  in  16  raw spike address: [15] param flag, [14] rich club, [13:7] second neuron, [6:0] first neuron
- mem_we  out  1  synapse memory write strobe
- mem_re  out  1  synapse memory read strobe
- mem_addr  out  AW  synapse memory address
- mem_wdata  out  DW  synapse memory write data
- mem_rdata  in  DW  synapse memory read data, valid 1 cycle after mem_re
- rd_valid  out  1  read-return strobe
- rd_data  out  DW  equals mem_rdata
- rd_neuron  out  AW  neuron index of the returned read
- rd_last  out  1  final read of the current spike
- err_drop  out  1  1-cycle pulse when an illegal spike is accepted and dropped

## Operation
- FSM states:
  - IDLE: accepts at most one request per cycle.
  - PAIR: issues the second read of a two-neuron spike; all readies are 0.
- Readies (combinational):
  - cfg_ready = IDLE.
  - swu_ready and spk_ready = IDLE & !cfg_valid, then the swu/spk policy (see Configuration).
  - Only one handshake can complete per cycle.
- cfg accept: next cycle mem_we=1, mem_addr=cfg_addr, mem_wdata=cfg_data.
- swu accept: next cycle mem_we=1, mem_addr=swu_addr, mem_wdata={24'b0, swu_data}.
- spk accept, classified by the spk_addr bits:
  - [15]=1: illegal. No memory access; err_drop pulses next cycle.
  - [14]=1 (rich club), or [13:7]==0: single read of [6:0], tagged rd_last=1.
  - Otherwise (two neurons): read [6:0] (rd_last=0), go to PAIR, then read [13:7] (rd_last=1), return to IDLE.
  - The second neuron index is latched at accept.
- A two-neuron pair is atomic; no write is interleaved between its two reads.
- mem_we and mem_re are never both 1.
- mem_addr and mem_wdata are 0 in any cycle with no strobe.

## Timing
- Reset values: all outputs 0, state IDLE, round-robin pointer = swu.
  - Readies follow their combinational equations: cfg_ready=1 in reset; swu/spk readies depend on cfg_valid and the policy.
- Accept at edge N: memory strobe registered, high in cycle N+1.
- Reads: rd_valid high in the cycle after mem_re. rd_neuron and rd_last are delayed with it.
- Two-neuron spike accepted at edge N: reads issued in cycles N+1 and N+2; rd_valid in N+2 and N+3. The next accept is possible at edge N+2.
- Sustained throughput: 1 operation per cycle, except each pair costs 2 cycles.
- Reset asserted mid-PAIR: state forced to IDLE, the pending second read is not issued, rd_valid and err_drop are cleared immediately.
- Simultaneous cfg, swu and spk valids: cfg always wins. swu/spk are resolved per Configuration.

## Configuration
- SCHED_RR_EN defined: swu and spk alternate round-robin.
  - The pointer toggles only when the favoured requester completes a handshake.
  - An idle favoured requester yields to the other.
- SCHED_RR_EN undefined: fixed priority swu > spk. No pointer register.

## Test plan
- Reset, then cfg write addr 0x05 data 0xDEADBEEF -> mem_we=1, mem_addr=0x05, mem_wdata=0xDEADBEEF one cycle after accept.
- swu addr 0x7F data 0xA5 -> mem_wdata=0x000000A5 at addr 0x7F.
- spk_addr 0x0283 (second neuron 0x05, first 0x03) -> mem_re at 0x03 then 0x05 on consecutive cycles. rd_valid two cycles with rd_neuron 0x03/rd_last=0, then 0x05/rd_last=1. spk_ready=0 during PAIR.
- spk_addr 0x4003 and 0x0003 -> each gives a single read of 0x03 with rd_last=1. spk_addr 0x8003 -> no mem strobe, err_drop pulse.
- cfg, swu and spk held valid together for 6 cycles:
  - cfg is served every cycle.
  - Drop cfg: with SCHED_RR_EN, swu and spk alternate; without it, swu is served every cycle and spk is starved.
- Assert rst in the cycle after a two-neuron accept -> no second mem_re, rd_valid=0, state IDLE after release.

Source files
------------

// File: rtl/synapse_port_scheduler_if.sv
// rtl/synapse_port_scheduler_if.sv - request, memory and read-return signals of the synapse port scheduler
//
// Purpose: bundles every handshake and bus signal of synapse_port_scheduler so
// the scheduler and its environment share one typed connection.
//
// Signal groups:
//   cfg_*      AXI parameter write (valid/ready, AW address, DW data)
//   swu_*      STDP weight update (valid/ready, AW address, 8-bit weight)
//   spk_*      spike read (valid/ready, 16-bit raw spike address)
//   mem_*      synapse memory port (we, re, addr, wdata out; rdata in)
//   rd_*       tagged read return towards the soma (valid, data, neuron, last)
//   err_drop   one-cycle pulse for a dropped illegal spike
//
// Modports:
//   slave   the scheduler
//   master  the surrounding logic (requesters, synapse memory, soma)

interface synapse_port_scheduler_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;

    logic          swu_valid;
    logic          swu_ready;
    logic [AW-1:0] swu_addr;
    logic [7:0]    swu_data;

    logic          spk_valid;
    logic          spk_ready;
    logic [15:0]   spk_addr;

    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_neuron;
    logic          rd_last;
    logic          err_drop;

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data,
        input  swu_valid, swu_addr, swu_data,
        input  spk_valid, spk_addr,
        input  mem_rdata,
        output cfg_ready, swu_ready, spk_ready,
        output mem_we, mem_re, mem_addr, mem_wdata,
        output rd_valid, rd_data, rd_neuron, rd_last, err_drop
    );

    modport master (
        output cfg_valid, cfg_addr, cfg_data,
        output swu_valid, swu_addr, swu_data,
        output spk_valid, spk_addr,
        output mem_rdata,
        input  cfg_ready, swu_ready, spk_ready,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        input  rd_valid, rd_data, rd_neuron, rd_last, err_drop
    );
endinterface

// File: rtl/synapse_port_scheduler.sv
// rtl/synapse_port_scheduler.sv - arbiter for the single synapse-memory port of a processing neuron
//
// Purpose: shares one 128-entry synapse memory port between AXI parameter
// writes (cfg), STDP weight updates (swu) and spike-driven weight reads (spk).
// A two-neuron spike expands into two back-to-back reads; read data returns
// tagged with the neuron index and a last-of-spike flag.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   bus        synapse_port_scheduler_if.slave
//              cfg_valid/ready, cfg_addr, cfg_data   parameter write
//              swu_valid/ready, swu_addr, swu_data   weight update (8-bit, zero-extended)
//              spk_valid/ready, spk_addr             spike read: [15] param flag (illegal),
//                                                    [14] rich club, [13:7] second neuron,
//                                                    [6:0] first neuron
//              mem_we, mem_re, mem_addr, mem_wdata   registered memory strobes
//              mem_rdata                             memory data, one cycle after mem_re
//              rd_valid, rd_data, rd_neuron, rd_last read return
//              err_drop                              illegal spike dropped
//
// Build option: SCHED_RR_EN
//   defined    swu and spk share the port round-robin
//   undefined  fixed priority swu > spk
// cfg always has priority over both.

module synapse_port_scheduler #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic clk,
    input  logic rst,
    synapse_port_scheduler_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PAIR = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request acceptance
    logic          arb_open;
    logic          cfg_rdy;
    logic          swu_rdy;
    logic          spk_rdy;
    logic          cfg_fire;
    logic          swu_fire;
    logic          spk_fire;

    // Spike address decode
    logic [AW-1:0] spk_first;
    logic [AW-1:0] spk_second;
    logic          spk_illegal;
    logic          spk_single;
    logic [AW-1:0] pair_addr;

    // Next values of the registered memory-side outputs
    logic          we_d;
    logic          re_d;
    logic          last_d;
    logic          err_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

    // Registered outputs
    logic          mem_we_q;
    logic          mem_re_q;
    logic          mem_last_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          err_drop_q;
    logic          rd_valid_q;
    logic [AW-1:0] rd_neuron_q;
    logic          rd_last_q;

    assign spk_first   = bus.spk_addr[AW-1:0];
    assign spk_second  = bus.spk_addr[2*AW-1:AW];
    assign spk_illegal = bus.spk_addr[15];
    // Rich-club spikes and spikes with no second neuron need only one read.
    assign spk_single  = bus.spk_addr[14] || (spk_second == '0);

    // ------------------------------------------------------------------
    // Readies. cfg wins outright; swu/spk only see the port when cfg is
    // quiet, so at most one handshake completes per cycle.
    // ------------------------------------------------------------------
`ifdef SCHED_RR_EN
    // rr_spk = 0 favours swu, 1 favours spk. The favoured requester yields
    // only when it is not asking; the pointer moves only when the favoured
    // side is actually served, so a yield does not cost it its turn.
    logic rr_spk;

    always_comb begin
        arb_open = (state == IDLE) && !bus.cfg_valid;
        cfg_rdy  = (state == IDLE);
        swu_rdy  = arb_open && (!rr_spk || !bus.spk_valid);
        spk_rdy  = arb_open && ( rr_spk || !bus.swu_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_spk <= 1'b0;
        end else if (!rr_spk && swu_fire) begin
            rr_spk <= 1'b1;
        end else if (rr_spk && spk_fire) begin
            rr_spk <= 1'b0;
        end
    end
`else
    always_comb begin
        arb_open = (state == IDLE) && !bus.cfg_valid;
        cfg_rdy  = (state == IDLE);
        swu_rdy  = arb_open;
        spk_rdy  = arb_open && !bus.swu_valid;
    end
`endif

    assign cfg_fire = bus.cfg_valid && cfg_rdy;
    assign swu_fire = bus.swu_valid && swu_rdy;
    assign spk_fire = bus.spk_valid && spk_rdy;

    assign bus.cfg_ready = cfg_rdy;
    assign bus.swu_ready = swu_rdy;
    assign bus.spk_ready = spk_rdy;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. PAIR lasts exactly one cycle; holding all readies
    // low there keeps the two reads of a pair back-to-back.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (spk_fire && !spk_illegal && !spk_single) begin
                    state_nxt = PAIR;
                end
            end
            PAIR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Produces the next memory command; everything is
    // registered below so strobes appear the cycle after the accept.
    // Address and data stay 0 whenever no strobe is issued.
    // ------------------------------------------------------------------
    always_comb begin
        we_d    = 1'b0;
        re_d    = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        unique case (state)
            IDLE: begin
                if (cfg_fire) begin
                    we_d    = 1'b1;
                    addr_d  = bus.cfg_addr;
                    wdata_d = bus.cfg_data;
                end else if (swu_fire) begin
                    we_d    = 1'b1;
                    addr_d  = bus.swu_addr;
                    wdata_d = {{(DW-8){1'b0}}, bus.swu_data};
                end else if (spk_fire) begin
                    if (spk_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        re_d   = 1'b1;
                        addr_d = spk_first;
                        last_d = spk_single;
                    end
                end
            end
            PAIR: begin
                re_d   = 1'b1;
                addr_d = pair_addr;
                last_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Second neuron is captured at accept; spk_addr may change afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_addr <= '0;
        end else if (state == IDLE && spk_fire) begin
            pair_addr <= spk_second;
        end
    end

    // Memory command and error pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_last_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            mem_we_q    <= we_d;
            mem_re_q    <= re_d;
            mem_last_q  <= last_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            err_drop_q  <= err_d;
        end
    end

    // Read-return tags ride one cycle behind mem_re to line up with mem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q  <= 1'b0;
            rd_neuron_q <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            rd_valid_q  <= mem_re_q;
            rd_neuron_q <= mem_re_q ? mem_addr_q : '0;
            rd_last_q   <= mem_re_q && mem_last_q;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err_drop  = err_drop_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.rd_neuron = rd_neuron_q;
    assign bus.rd_last   = rd_last_q;

endmodule

// File: tb/tb_synapse_port_scheduler.sv
// tb/tb_synapse_port_scheduler.sv - scoreboard bench for synapse_port_scheduler

module tb_synapse_port_scheduler;

    logic clk;
    logic rst;
    int   cyc_cnt;
    int   checks;
    int   failures;

    synapse_port_scheduler_if #(.AW(7), .DW(32)) bus ();

    synapse_port_scheduler #(.AW(7), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        bit          we;
        bit          re;
        bit          err;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [6:0]  neuron;
        bit          last;
    } rd_exp_t;

    mem_exp_t mq[$];
    rd_exp_t  rq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Memory contents seen by reads: a fixed pattern tagged with the address.
    function automatic logic [31:0] mem_pattern(input logic [6:0] a);
        return {16'hC0DE, 9'b0, a};
    endfunction

    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_re ? mem_pattern(bus.mem_addr) : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic push_mem(input int c, input bit we, input bit re, input bit err,
                            input logic [6:0] a, input logic [31:0] d);
        mem_exp_t e;
        e.cyc = c; e.we = we; e.re = re; e.err = err; e.addr = a; e.wdata = d;
        mq.push_back(e);
    endtask

    task automatic push_rd(input int c, input logic [6:0] n, input bit last);
        rd_exp_t e;
        e.cyc = c; e.neuron = n; e.last = last;
        rq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented memory command / read return against
    // the head of its queue, and checks the quiet-bus invariants otherwise.
    always @(negedge clk) begin
        mem_exp_t me;
        rd_exp_t  re;
        chk("we_re_exclusive", 32'(bus.mem_we & bus.mem_re), 32'h0);
        if (!bus.mem_we && !bus.mem_re) begin
            chk("quiet_addr", 32'(bus.mem_addr), 32'h0);
            chk("quiet_wdata", bus.mem_wdata, 32'h0);
        end
        if (bus.mem_we || bus.mem_re || bus.err_drop) begin
            if (mq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_mem_op actual=we%0b/re%0b/err%0b addr=0x%0h required=none (cycle %0d)",
                         bus.mem_we, bus.mem_re, bus.err_drop, bus.mem_addr, cyc_cnt);
            end else begin
                me = mq.pop_front();
                chk("mem_cycle", 32'(cyc_cnt), 32'(me.cyc));
                chk("mem_we", 32'(bus.mem_we), 32'(me.we));
                chk("mem_re", 32'(bus.mem_re), 32'(me.re));
                chk("err_drop", 32'(bus.err_drop), 32'(me.err));
                if (me.we || me.re) chk("mem_addr", 32'(bus.mem_addr), 32'(me.addr));
                if (me.we) chk("mem_wdata", bus.mem_wdata, me.wdata);
            end
        end
        if (bus.rd_valid) begin
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd actual=neuron 0x%0h required=none (cycle %0d)",
                         bus.rd_neuron, cyc_cnt);
            end else begin
                re = rq.pop_front();
                chk("rd_cycle", 32'(cyc_cnt), 32'(re.cyc));
                chk("rd_neuron", 32'(bus.rd_neuron), 32'(re.neuron));
                chk("rd_last", 32'(bus.rd_last), 32'(re.last));
                chk("rd_data", bus.rd_data, mem_pattern(re.neuron));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int acc;
        logic [15:0] singles[3];
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.swu_valid = 1'b0; bus.swu_addr = '0; bus.swu_data = '0;
        bus.spk_valid = 1'b0; bus.spk_addr = '0;
        repeat (3) step();

        // Reset state
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_err_drop", 32'(bus.err_drop), 32'h0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'h1);
        chk("rst_swu_ready", 32'(bus.swu_ready), 32'h1);
        chk("rst_spk_ready", 32'(bus.spk_ready), 32'h1);
        rst = 1'b1;
        step();

        // cfg write
        bus.cfg_valid = 1'b1; bus.cfg_addr = 7'h05; bus.cfg_data = 32'hDEADBEEF;
        acc = cyc_cnt + 1;
        push_mem(acc, 1, 0, 0, 7'h05, 32'hDEADBEEF);
        step();
        bus.cfg_valid = 1'b0;

        // swu write, zero-extended weight
        bus.swu_valid = 1'b1; bus.swu_addr = 7'h7F; bus.swu_data = 8'hA5;
        acc = cyc_cnt + 1;
        push_mem(acc, 1, 0, 0, 7'h7F, 32'h000000A5);
        step();
        bus.swu_valid = 1'b0;

        // Two-neuron spike: reads 0x03 then 0x05
        bus.spk_valid = 1'b1; bus.spk_addr = 16'h0283;
        acc = cyc_cnt + 1;
        push_mem(acc,     0, 1, 0, 7'h03, 32'h0);
        push_mem(acc + 1, 0, 1, 0, 7'h05, 32'h0);
        push_rd(acc + 1, 7'h03, 0);
        push_rd(acc + 2, 7'h05, 1);
        step();
        bus.spk_valid = 1'b1; bus.swu_valid = 1'b1; bus.cfg_valid = 1'b1;
        #1;
        chk("pair_spk_ready", 32'(bus.spk_ready), 32'h0);
        chk("pair_swu_ready", 32'(bus.swu_ready), 32'h0);
        chk("pair_cfg_ready", 32'(bus.cfg_ready), 32'h0);
        bus.spk_valid = 1'b0; bus.swu_valid = 1'b0; bus.cfg_valid = 1'b0;
        step();

        // Single reads and the illegal spike, back to back
        singles[0] = 16'h4003;
        singles[1] = 16'h0003;
        singles[2] = 16'h8003;
        for (int i = 0; i < 3; i++) begin
            bus.spk_valid = 1'b1; bus.spk_addr = singles[i];
            acc = cyc_cnt + 1;
            if (i < 2) begin
                push_mem(acc, 0, 1, 0, 7'h03, 32'h0);
                push_rd(acc + 1, 7'h03, 1);
            end else begin
                push_mem(acc, 0, 0, 1, 7'h00, 32'h0);
            end
            step();
        end
        bus.spk_valid = 1'b0;
        repeat (2) step();

        // Contention: cfg always wins
        bus.cfg_valid = 1'b1;
        bus.swu_valid = 1'b1; bus.swu_addr = 7'h20; bus.swu_data = 8'h5A;
        bus.spk_valid = 1'b1; bus.spk_addr = 16'h4011;
        for (int i = 0; i < 6; i++) begin
            bus.cfg_addr = 7'(7'h40 + i);
            bus.cfg_data = 32'h1000_0000 + 32'(i);
            acc = cyc_cnt + 1;
            push_mem(acc, 1, 0, 0, 7'(7'h40 + i), 32'h1000_0000 + 32'(i));
            if (i == 0) begin
                #1;
                chk("contend_swu_ready", 32'(bus.swu_ready), 32'h0);
                chk("contend_spk_ready", 32'(bus.spk_ready), 32'h0);
            end
            step();
        end
        bus.cfg_valid = 1'b0;

        // cfg dropped: swu vs spk
        for (int i = 0; i < 4; i++) begin
            acc = cyc_cnt + 1;
`ifdef SCHED_RR_EN
            if (i % 2 == 1) begin
                push_mem(acc, 0, 1, 0, 7'h11, 32'h0);
                push_rd(acc + 1, 7'h11, 1);
            end else begin
                push_mem(acc, 1, 0, 0, 7'h20, 32'h0000005A);
            end
`else
            push_mem(acc, 1, 0, 0, 7'h20, 32'h0000005A);
`endif
            step();
        end
        bus.swu_valid = 1'b0; bus.spk_valid = 1'b0;
        repeat (3) step();

        // Reset in the cycle after a two-neuron accept: everything cancelled
        bus.spk_valid = 1'b1; bus.spk_addr = 16'h0283;
        step();
        bus.spk_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midpair_rst_mem_re", 32'(bus.mem_re), 32'h0);
        chk("midpair_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("midpair_rst_err_drop", 32'(bus.err_drop), 32'h0);
        chk("midpair_rst_cfg_ready", 32'(bus.cfg_ready), 32'h1);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'h1);
        chk("post_rst_spk_ready", 32'(bus.spk_ready), 32'h1);
        repeat (3) step();

        // Port still usable after reset
        bus.cfg_valid = 1'b1; bus.cfg_addr = 7'h11; bus.cfg_data = 32'h12345678;
        acc = cyc_cnt + 1;
        push_mem(acc, 1, 0, 0, 7'h11, 32'h12345678);
        step();
        bus.cfg_valid = 1'b0;
        repeat (4) step();

        chk("mem_queue_drained", 32'(mq.size()), 32'h0);
        chk("rd_queue_drained", 32'(rq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
